tff_seq_ctrl: RTL and testbench
===============================

// Module: tff_seq_ctrl
// PURPOSE
//   Sequencer for an external bank of WIDTH T flip-flops. Accepts a command over a
//   valid/ready handshake and drives the bank's T inputs (t_out) with toggle patterns
//   computed from the bank's Q feedback (q_fb). Supports mask-toggle, clear, set and
//   up-count operations. Sits between a control master and a tff_bank of t_flip_flop cells.
// PARAMETERS
//   WIDTH  4  number of T flip-flops in the controlled bank
//   CNT_W  8  width of cmd_len / step counter (COUNT supports up to 2**CNT_W-1 steps)
// PORTS
//   clk        in   1       rising-edge clock, shared with the T flip-flop bank
//   rst_n      in   1       asynchronous active-low reset
//   cmd_valid  in   1       command present
//   cmd_ready  out  1       controller can accept; high only in IDLE
//   cmd_op     in   2       00 TOGGLE, 01 COUNT, 10 CLEAR, 11 SET
//   cmd_mask   in   WIDTH   bit select for TOGGLE/CLEAR/SET (ignored by COUNT)
//   cmd_len    in   CNT_W   number of increment steps for COUNT (ignored otherwise)
//   abort      in   1       synchronous abort of the running command
//   q_fb       in   WIDTH   Q outputs of the bank
//   t_out      out  WIDTH   registered T inputs to the bank
//   busy       out  1       state != IDLE
//   done       out  1       one-cycle pulse at command completion or abort
//   aborted    out  1       valid with done: 1 = command was aborted
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; t_out=0, done=0, aborted=0, busy=0, cmd_ready=1
//   after release. Reset mid-command drops the command; bank state is not touched.
// - FSM: IDLE -> PULSE -> GAP -> (PULSE | DONE) -> IDLE.
// - Accept on posedge when cmd_valid && cmd_ready. Latch op, mask, len; steps = 1
//   (COUNT: steps = cmd_len). COUNT with cmd_len=0: IDLE -> DONE directly, no pulse.
// - On each edge entering PULSE, t_out <= pattern from current q_fb:
//   TOGGLE: mask. CLEAR: q_fb & mask. SET: ~q_fb & mask.
//   COUNT: t[0]=1, t[i]=&q_fb[i-1:0] (binary +1; all-ones wraps to 0).
// - PULSE lasts 1 cycle; bank toggles on the edge ending PULSE. GAP lasts 1 cycle with
//   t_out=0 and q_fb already updated. Steps are 2 cycles each; steps decrements on
//   leaving GAP. steps==0 leaving GAP -> DONE, else -> PULSE with a recomputed pattern.
// - DONE lasts 1 cycle: done=1, t_out=0, cmd_ready=0; then IDLE.
// - t_out is nonzero only in PULSE. CLEAR/SET with nothing to change still spends
//   PULSE+GAP with t_out=0.
// - abort sampled in PULSE or GAP: next state DONE with aborted=1. A pulse already
//   driven completes in the bank. abort in IDLE/DONE: ignored.
// - cmd_valid while busy: not accepted, no side effect. Master holds the command.
// - Latency: TOGGLE/CLEAR/SET accept-to-done = 3 cycles; COUNT = 2*len+1.
// TESTING
// 1 reset mid-COUNT (len=8, after 3 steps) -> t_out=0, busy=0 immediately; q_fb stays 0011;
//   a new TOGGLE after release is accepted.
// 2 q=0000, TOGGLE mask=1010 -> t_out=1010 for 1 cycle, q=1010, done 3 cycles after accept.
// 3 q=0000, COUNT len=5 -> q steps 1,2,3,4,5, t_out=0 in every GAP, done at cycle 11, q=0101.
// 4 q=1110, COUNT len=3 -> q=1111, 0000 (wrap), 0001; COUNT len=0 -> done after 1 cycle, no pulse.
// 5 q=0110: CLEAR mask=0011 -> q=0100; SET mask=1001 -> q=1101; SET mask=0100 -> t_out=0000.
// 6 COUNT len=10, abort in 2nd GAP -> done=1, aborted=1, q=0010; cmd_valid held while busy
//   is accepted only after DONE.

Source files
------------

// File: rtl/tff_seq_ctrl_if.sv
// Command handshake between a control master and the T flip-flop sequencer.
// The master drives the command fields and abort; the sequencer answers with cmd_ready.
interface tff_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_len, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_len, abort,
    output cmd_ready
  );
endinterface

// File: rtl/tff_seq_ctrl.sv
// Sequencer driving the T inputs of an external T flip-flop bank from its Q feedback.
// Each step is one PULSE cycle (pattern on t_out) followed by one GAP cycle (t_out = 0).
module tff_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tff_seq_ctrl_if.slave    cmd,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    OP_TOGGLE = 2'b00,
    OP_COUNT  = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_SET    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PULSE = 2'b01,
    S_GAP   = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] t_out_q, t_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             ready_q, ready_d;

  // Toggle pattern for one step, derived from the bank's present Q value.
  function automatic logic [WIDTH-1:0] step_pattern(input op_e op,
                                                    input logic [WIDTH-1:0] mask,
                                                    input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] p;
    p = '0;
    case (op)
      OP_TOGGLE: p = mask;
      OP_CLEAR:  p = q & mask;
      OP_SET:    p = ~q & mask;
      OP_COUNT: begin
        // Ripple-carry increment: bit i flips when every lower bit is one.
        p[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
          p[i] = p[i-1] & q[i-1];
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d   = state_q;
    op_d      = op_q;
    mask_d    = mask_q;
    steps_d   = steps_q;
    t_out_d   = '0;
    aborted_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid && ready_q) begin
          op_d   = op_e'(cmd.cmd_op);
          mask_d = cmd.cmd_mask;
          if (op_d == OP_COUNT) begin
            steps_d = cmd.cmd_len;
          end else begin
            steps_d = CNT_W'(1);
          end
          if (steps_d == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PULSE;
            t_out_d = step_pattern(op_d, mask_d, q_fb);
          end
        end
      end

      S_PULSE: begin
        // The pulse already on t_out still lands in the bank on this edge.
        if (cmd.abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (cmd.abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          steps_d = steps_q - CNT_W'(1);
          if (steps_d == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PULSE;
            t_out_d = step_pattern(op_q, mask_q, q_fb);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered versions of what the next state implies.
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  // NOTE: the command registers are reset along with the state so that nothing
  // downstream ever observes X after reset; they are few flops, not a memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_TOGGLE;
      mask_q    <= '0;
      steps_q   <= '0;
      t_out_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q   <= state_d;
      op_q      <= op_d;
      mask_q    <= mask_d;
      steps_q   <= steps_d;
      t_out_q   <= t_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign t_out         = t_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Self-checking bench for tff_seq_ctrl: emulates the T flip-flop bank and compares
// every cycle against a transaction-level model that precomputes each command's output stream.
module tb_tff_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  localparam logic [1:0] OP_TOGGLE = 2'b00;
  localparam logic [1:0] OP_COUNT  = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_SET    = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] bank_q = '0;
  logic [WIDTH-1:0] t_out;
  logic             busy, done, aborted;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  tff_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cif ();

  tff_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cif),
    .q_fb    (bank_q),
    .t_out   (t_out),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  // External T flip-flop bank: each bit toggles when its T input is high.
  always @(posedge clk) bank_q <= bank_q ^ t_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [WIDTH-1:0] t;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             ready;
  } exp_t;

  localparam exp_t IDLE_EXP = '{t: '0, busy: 1'b0, done: 1'b0, aborted: 1'b0, ready: 1'b1};

  exp_t             cur = IDLE_EXP;
  exp_t             expq[$];
  logic [WIDTH-1:0] mq = '0;

  function automatic logic [WIDTH-1:0] model_pattern(input logic [1:0] op,
                                                     input logic [WIDTH-1:0] m,
                                                     input logic [WIDTH-1:0] q);
    case (op)
      OP_TOGGLE: return m;
      OP_CLEAR:  return q & m;
      OP_SET:    return ~q & m;
      default:   return WIDTH'(q + 1'b1) ^ q;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expq.delete();
      cur = IDLE_EXP;
    end else begin
      logic [WIDTH-1:0] q;
      int               n;
      mq = mq ^ cur.t;
      if (cur.ready) begin
        if (cif.cmd_valid) begin
          n = (cif.cmd_op == OP_COUNT) ? int'(cif.cmd_len) : 1;
          q = mq;
          for (int k = 0; k < n; k++) begin
            logic [WIDTH-1:0] p;
            p = model_pattern(cif.cmd_op, cif.cmd_mask, q);
            expq.push_back('{t: p,  busy: 1'b1, done: 1'b0, aborted: 1'b0, ready: 1'b0});
            expq.push_back('{t: '0, busy: 1'b1, done: 1'b0, aborted: 1'b0, ready: 1'b0});
            q = q ^ p;
          end
          expq.push_back('{t: '0, busy: 1'b1, done: 1'b1, aborted: 1'b0, ready: 1'b0});
        end
      end else if (cif.abort && !cur.done) begin
        expq.delete();
        expq.push_back('{t: '0, busy: 1'b1, done: 1'b1, aborted: 1'b1, ready: 1'b0});
      end
      cur = (expq.size() > 0) ? expq.pop_front() : IDLE_EXP;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("t_out",     t_out,         cur.t);
      check("busy",      busy,          cur.busy);
      check("done",      done,          cur.done);
      check("aborted",   aborted,       cur.aborted);
      check("cmd_ready", cif.cmd_ready, cur.ready);
      check("bank_q",    bank_q,        mq);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Presents a command and holds it until accepted; returns with the
  // accepting edge just behind (cycle 1 of the command).
  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] m,
                       input logic [CNT_W-1:0] l, output int waited);
    logic acc;
    waited = 0;
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_mask  = m;
    cif.cmd_len   = l;
    do begin
      acc = cif.cmd_ready;
      @(posedge clk); #2;
      waited++;
    end while (!acc && waited < 40);
    check("accepted", acc, 1);
    cif.cmd_valid = 1'b0;
  endtask

  // Counts cycles from cycle 1 of a command until done is seen.
  task automatic wait_done(output int c);
    c = 1;
    while (done !== 1'b1 && c < 700) begin
      @(posedge clk); #2;
      c++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic run(input logic [1:0] op, input logic [WIDTH-1:0] m,
                     input logic [CNT_W-1:0] l, output int c);
    int w;
    issue(op, m, l, w);
    wait_done(c);
  endtask

  initial begin
    int c, w;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = OP_TOGGLE;
    cif.cmd_mask  = '0;
    cif.cmd_len   = '0;
    cif.abort     = 1'b0;

    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_t_out", t_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cif.cmd_ready, 1);
    rst_n = 1'b1;

    // 1: reset in the GAP of the third COUNT step
    issue(OP_COUNT, '0, 8'd8, w);
    repeat (5) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    check("t1_t_out", t_out, 0);
    check("t1_busy", busy, 0);
    check("t1_q", bank_q, 4'b0011);
    repeat (2) begin @(posedge clk); #2; end
    check("t1_q_hold", bank_q, 4'b0011);
    rst_n = 1'b1;
    run(OP_TOGGLE, 4'b0011, '0, c);
    check("t1_toggle_lat", c, 3);

    // 2: TOGGLE from 0000
    issue(OP_TOGGLE, 4'b1010, '0, w);
    check("t2_pulse", t_out, 4'b1010);
    wait_done(c);
    check("t2_lat", c, 3);
    check("t2_q", bank_q, 4'b1010);

    // 3: COUNT 5 from 0000
    run(OP_TOGGLE, 4'b1010, '0, c);
    run(OP_COUNT, '0, 8'd5, c);
    check("t3_lat", c, 11);
    check("t3_q", bank_q, 4'b0101);

    // 4: COUNT wrap from 1110, then COUNT len=0
    run(OP_TOGGLE, 4'b1011, '0, c);
    check("t4_q_start", bank_q, 4'b1110);
    run(OP_COUNT, '0, 8'd3, c);
    check("t4_lat", c, 7);
    check("t4_q", bank_q, 4'b0001);
    run(OP_COUNT, '0, 8'd0, c);
    check("t4_len0_lat", c, 1);
    check("t4_len0_q", bank_q, 4'b0001);

    // 5: CLEAR / SET from 0110
    run(OP_TOGGLE, 4'b0111, '0, c);
    run(OP_CLEAR, 4'b0011, '0, c);
    check("t5_clear_q", bank_q, 4'b0100);
    run(OP_SET, 4'b1001, '0, c);
    check("t5_set_q", bank_q, 4'b1101);
    issue(OP_SET, 4'b0100, '0, w);
    check("t5_set_noop_t", t_out, 4'b0000);
    wait_done(c);
    check("t5_set_noop_lat", c, 2 + 1);
    check("t5_set_noop_q", bank_q, 4'b1101);

    // 6: abort in the second GAP, with the next command held while busy
    run(OP_TOGGLE, 4'b1101, '0, c);
    issue(OP_COUNT, '0, 8'd10, w);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = OP_TOGGLE;
    cif.cmd_mask  = 4'b0001;
    cif.cmd_len   = '0;
    repeat (3) begin @(posedge clk); #2; end
    cif.abort = 1'b1;
    @(posedge clk); #2;
    cif.abort = 1'b0;
    check("t6_done", done, 1);
    check("t6_aborted", aborted, 1);
    check("t6_q", bank_q, 4'b0010);
    issue(OP_TOGGLE, 4'b0001, '0, w);
    check("t6_accept_wait", w, 2);
    wait_done(c);
    check("t6_lat", c, 3);
    check("t6_q_final", bank_q, 4'b0011);

    // Randomized traffic, including aborts, idle aborts and occasional resets
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      cif.cmd_valid = ($urandom_range(0, 3) == 0);
      cif.cmd_op    = 2'($urandom_range(0, 3));
      cif.cmd_mask  = 4'($urandom);
      cif.cmd_len   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40))
                                                   : 8'($urandom_range(0, 4));
      cif.abort     = ($urandom_range(0, 11) == 0);
      rst_n         = ($urandom_range(0, 299) != 0);
    end
    @(posedge clk); #2;
    cif.cmd_valid = 1'b0;
    cif.abort     = 1'b0;
    rst_n         = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk); #1;
    check("end_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
